// File: rtl/cpu_sequencer.sv
// cpu_sequencer: micro-step FSM walking each instruction through fetch, decode and a class-specific execute sequence
// Optional single-step support is enabled by defining COCC_SINGLE_STEP_EN (adds step_mode/step_req inputs).
// State encodings mirror the STATE_* constants consumed by the control decoder.
module cpu_sequencer #(
  parameter logic [7:0] RESET_STATE = 8'h00,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ir,
  input  logic             resume,
`ifdef COCC_SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step_req,
`endif
  output logic [7:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [7:0] {
    STATE_FETCH_PC   = 8'h00,
    STATE_FETCH_INST = 8'h01,
    STATE_DECODE     = 8'h02,
    STATE_ALU_EXEC   = 8'h03,
    STATE_ALU_OUT    = 8'h04,
    STATE_MOV_REG    = 8'h05,
    STATE_SET_REG    = 8'h06,
    STATE_SET_MAR    = 8'h07,
    STATE_SET_MEM    = 8'h08,
    STATE_JUMP       = 8'h09,
    STATE_FETCH_SP   = 8'h0A,
    STATE_STORE_PC   = 8'h0B,
    STATE_TMP_JUMP   = 8'h0C,
    STATE_INC_SP     = 8'h0D,
    STATE_RET        = 8'h0E,
    STATE_STACK_REG  = 8'h0F,
    STATE_RIN_STORE  = 8'h10,
    STATE_ROUT_STORE = 8'h11,
    STATE_LOAD_ADDR  = 8'h12,
    STATE_MIN_STORE  = 8'h13,
    STATE_MOUT_STORE = 8'h14,
    STATE_HALT       = 8'h15
  } state_t;

  localparam logic [3:0] CLS_NOP = 4'h0;
  localparam logic [3:0] CLS_ILL = 4'h0E;

  state_t           cur, nxt;
  logic             exec_q, exec_d;
  logic [1:0]       step_q, step_d;
  logic [3:0]       cls_q, cls_d;
  logic             ill_q, ill_d;
  logic             done;
  logic             go;
  logic [CNT_W-1:0] ret_q;

  // Execute-step table: micro-state for class c at step index s.
  function automatic state_t seq_at(input logic [3:0] c, input logic [1:0] s);
    case (c)
      4'h1:    seq_at = (s == 2'd0) ? STATE_ALU_EXEC : STATE_ALU_OUT;
      4'h2:    seq_at = STATE_MOV_REG;
      4'h3:    seq_at = (s == 2'd0) ? STATE_FETCH_PC : STATE_SET_REG;
      4'h4:    seq_at = (s == 2'd0) ? STATE_SET_MAR : STATE_SET_MEM;
      4'h5:    seq_at = (s == 2'd0) ? STATE_FETCH_PC : STATE_JUMP;
      4'h6:    seq_at = (s == 2'd0) ? STATE_FETCH_PC :
                        (s == 2'd1) ? STATE_FETCH_SP :
                        (s == 2'd2) ? STATE_STORE_PC : STATE_TMP_JUMP;
      4'h7:    seq_at = (s == 2'd0) ? STATE_INC_SP :
                        (s == 2'd1) ? STATE_FETCH_SP : STATE_RET;
      4'h8:    seq_at = (s == 2'd0) ? STATE_FETCH_SP : STATE_STACK_REG;
      4'h9:    seq_at = (s == 2'd0) ? STATE_INC_SP :
                        (s == 2'd1) ? STATE_FETCH_SP : STATE_SET_REG;
      4'hA:    seq_at = STATE_RIN_STORE;
      4'hB:    seq_at = STATE_ROUT_STORE;
      4'hC:    seq_at = (s == 2'd0) ? STATE_FETCH_PC :
                        (s == 2'd1) ? STATE_LOAD_ADDR : STATE_MIN_STORE;
      4'hD:    seq_at = (s == 2'd0) ? STATE_FETCH_PC :
                        (s == 2'd1) ? STATE_LOAD_ADDR : STATE_MOUT_STORE;
      4'hF:    seq_at = STATE_HALT;
      default: seq_at = STATE_FETCH_PC;
    endcase
  endfunction

  // Index of the final execute step for class c.
  function automatic logic [1:0] seq_last(input logic [3:0] c);
    case (c)
      4'h6:                      seq_last = 2'd3;
      4'h7, 4'h9, 4'hC, 4'hD:    seq_last = 2'd2;
      4'h1, 4'h3, 4'h4, 4'h5,
      4'h8:                      seq_last = 2'd1;
      default:                   seq_last = 2'd0;
    endcase
  endfunction

`ifdef COCC_SINGLE_STEP_EN
  logic req_q;
  // Remember previous step_req so each rising edge releases exactly one instruction.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) req_q <= 1'b0;
    else        req_q <= step_req;
  assign go = !step_mode || (step_req && !req_q);
`else
  assign go = 1'b1;
`endif

  // Next-state, step/class bookkeeping and completion pulse.
  always_comb begin
    nxt    = cur;
    exec_d = exec_q;
    step_d = step_q;
    cls_d  = cls_q;
    ill_d  = ill_q;
    done   = 1'b0;
    if (exec_q) begin
      if (step_q == seq_last(cls_q) && (cur != STATE_HALT || resume)) begin
        done   = 1'b1;
        nxt    = STATE_FETCH_PC;
        exec_d = 1'b0;
      end else if (cur != STATE_HALT) begin
        step_d = step_q + 2'd1;
        nxt    = seq_at(cls_q, step_q + 2'd1);
      end
    end else begin
      case (cur)
        STATE_FETCH_PC:   nxt = STATE_FETCH_INST;
        STATE_FETCH_INST: nxt = STATE_DECODE;
        STATE_DECODE: begin
          cls_d  = ir[7:4];
          step_d = 2'd0;
          if (go) begin
            if (ir[7:4] == CLS_NOP || ir[7:4] == CLS_ILL) begin
              done  = 1'b1;
              nxt   = STATE_FETCH_PC;
              ill_d = ill_q | (ir[7:4] == CLS_ILL);
            end else begin
              nxt    = seq_at(ir[7:4], 2'd0);
              exec_d = 1'b1;
            end
          end
        end
        default: nxt = state_t'(RESET_STATE);
      endcase
    end
  end

  // State, step index, latched class, sticky illegal flag and retired counter.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur    <= state_t'(RESET_STATE);
      exec_q <= 1'b0;
      step_q <= 2'd0;
      cls_q  <= 4'h0;
      ill_q  <= 1'b0;
      ret_q  <= '0;
    end else begin
      cur    <= nxt;
      exec_q <= exec_d;
      step_q <= step_d;
      cls_q  <= cls_d;
      ill_q  <= ill_d;
      ret_q  <= done ? ret_q + {{(CNT_W-1){1'b0}}, 1'b1} : ret_q;
    end

  assign state      = cur;
  assign instr_done = done;
  assign illegal    = ill_q;
  assign retired    = ret_q;
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Micro-step state machine that produces the 8-bit `state` word consumed by the control decoder.
- Walks every instruction through fetch, decode and a class-specific execute sequence, then returns to fetch.
- Sits between the IR and the control decoder. It is the only block that sequences the datapath (PC, MAR, RAM, SP, ALU, register file, GPIO).
- All state encodings are the `STATE_*` constants in symbols.vh. `STATE_DECODE` is added there; control asserts nothing in that state.

Parameters:
- RESET_STATE, `STATE_FETCH_PC, state entered on reset and after every instruction.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ir  in  8  instruction register contents. Valid from the cycle after `STATE_FETCH_INST`.
- resume  in  1  level; leaves `STATE_HALT` when sampled high.
- state  out  8  current micro-state, registered, to control.
- instr_done  out  1  one-cycle pulse in the last execute step of each instruction.
- illegal  out  1  sticky; set on an undefined opcode class.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: asynchronous on rst_n low, whatever the current step. Values: state=RESET_STATE, instr_done=0, illegal=0, retired=0, internal step index=0, latched class=0.
- Fetch: `STATE_FETCH_PC` -> `STATE_FETCH_INST` -> `STATE_DECODE`. One cycle each, unconditional.
- Decode: in `STATE_DECODE`, latch class = ir[7:4] and move to execute step 0 of that class. The class stays latched, so later IR changes do not affect the sequence.
- Execute sequences by class (one cycle per state, then `STATE_FETCH_PC`):
  - 0x0 NOP: no execute step; instr_done is pulsed in `STATE_DECODE`.
  - 0x1 ALU: ALU_EXEC, ALU_OUT
  - 0x2 MOV: MOV_REG
  - 0x3 LDI: FETCH_PC, SET_REG
  - 0x4 ST: SET_MAR, SET_MEM
  - 0x5 JMP/Jcc: FETCH_PC, JUMP. The flag decision stays in control; the sequence is identical taken or not taken.
  - 0x6 CALL: FETCH_PC, FETCH_SP, STORE_PC, TMP_JUMP
  - 0x7 RET: INC_SP, FETCH_SP, RET
  - 0x8 PUSH: FETCH_SP, STACK_REG
  - 0x9 POP: INC_SP, FETCH_SP, SET_REG
  - 0xA IN reg: RIN_STORE
  - 0xB OUT reg: ROUT_STORE
  - 0xC IN mem: FETCH_PC, LOAD_ADDR, MIN_STORE
  - 0xD OUT mem: FETCH_PC, LOAD_ADDR, MOUT_STORE
  - 0xF HLT: HALT
  - 0xE: illegal. Set `illegal`, execute as NOP, pulse instr_done.
- Step index: 2 bits, reset to 0 on entry to `STATE_DECODE`, incremented each execute cycle. A sequence never exceeds 4 steps, so it never wraps.
- instr_done: high exactly in the final execute cycle of each class, or in `STATE_DECODE` for NOP/illegal. `retired` increments on the same edge that ends that cycle and wraps modulo 2^CNT_W.
- HALT:
  - state holds `STATE_HALT` while resume=0.
  - resume=1 sampled in HALT -> instr_done pulses that cycle, next state `STATE_FETCH_PC`.
  - resume outside HALT is ignored.
  - Latency HALT -> FETCH_PC is 1 cycle.
- Unknown state value (unreachable): next state is RESET_STATE.
- `illegal` clears only on reset.

Optional Feature:
- Macro `COCC_SINGLE_STEP_EN`.
- Defined: adds inputs `step_mode` (1) and `step_req` (1).
  - With step_mode=1, the FSM parks in `STATE_DECODE` before each execute sequence until `step_req` is seen high for one cycle.
  - step_req is edge-qualified internally: one instruction per rising edge of step_req.
  - step_mode=0 gives normal flow.
  - HALT and reset behaviour are unchanged.
- Undefined: ports absent; decode always proceeds in 1 cycle.

Test Plan:
- Reset with ir=0x10 held, rst_n released at cycle 0 -> state sequence FETCH_PC, FETCH_INST, DECODE, ALU_EXEC, ALU_OUT, FETCH_PC. instr_done high only in ALU_OUT; retired=1.
- ir=0x60 (CALL) -> FETCH_PC, FETCH_INST, DECODE, FETCH_PC, FETCH_SP, STORE_PC, TMP_JUMP, FETCH_PC (8 cycles). Change ir to 0x00 after DECODE -> sequence unchanged.
- ir=0xF0 -> state holds HALT for 20 cycles with resume=0. Pulse resume=1 -> next cycle FETCH_PC; retired incremented once.
- ir=0xE5 -> illegal=1 after DECODE and stays 1 over the next ten 0x20 MOV instructions. rst_n low -> illegal=0.
- rst_n asserted low mid-CALL (in STORE_PC) -> state=FETCH_PC immediately without waiting for a clock edge; retired=0.
- Counter wrap: preload via 65535 NOPs (CNT_W=16) -> retired=0xFFFF; one more NOP -> retired=0x0000.
